// File: rtl/banked_read_memory.sv
// banked_read_memory: multi-read-port RAM with lane-masked writes, write-first bypass, 1/2-cycle read latency and post-reset clear
//   clk, rst (async, active low) | init_done: memory accepts traffic
//   w_en, w_addr, w_data, w_mask: single lane-masked write port
//   r_en, r_addr: per-port read requests (packed) | r_data, r_valid: per-port results (packed)
module banked_read_memory #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int LANE_BITS      = 8,
  parameter int READ_PORTS     = 2,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES         = DATA_BITS / LANE_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             init_done,
  input  logic                             w_en,
  input  logic [ADDR_BITS-1:0]             w_addr,
  input  logic [DATA_BITS-1:0]             w_data,
  input  logic [LANES-1:0]                 w_mask,
  input  logic [READ_PORTS-1:0]            r_en,
  input  logic [READ_PORTS*ADDR_BITS-1:0]  r_addr,
  output logic [READ_PORTS*DATA_BITS-1:0]  r_data,
  output logic [READ_PORTS-1:0]            r_valid
);
  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0] LAST = {1'b0, {ADDR_BITS{1'b1}}};
  localparam logic [ADDR_BITS:0] ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  if (DATA_BITS % LANE_BITS != 0) begin : g_bad_lanes
    $error("DATA_BITS must be an integer multiple of LANE_BITS");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (READ_PORTS < 1) begin : g_bad_ports
    $error("READ_PORTS must be at least 1");
  end
  typedef enum logic {CLEAR, READY} state_t;
  state_t                          state_q, state_d;
  logic [ADDR_BITS:0]              cnt_q, cnt_d;
  logic                            init_done_q, init_done_d;
  logic [READ_PORTS*DATA_BITS-1:0] s1_data_q, s1_data_d;
  logic [READ_PORTS-1:0]           s1_valid_q, s1_valid_d;
  logic [READ_PORTS*DATA_BITS-1:0] r_data_q, r_data_d;
  logic [READ_PORTS-1:0]           r_valid_q, r_valid_d;
  logic [DATA_BITS-1:0]            mem_q [DEPTH];
  logic                            ready, mem_we;
  logic [ADDR_BITS-1:0]            mem_wa;
  logic [DATA_BITS-1:0]            mem_wd, wbits;
  logic [ADDR_BITS-1:0]            rd_addr [READ_PORTS];
  logic [DATA_BITS-1:0]            rd_word [READ_PORTS];
  logic [READ_PORTS-1:0]           rd_acc;
  always_comb begin
    ready       = state_q == READY;
    cnt_d       = ready ? cnt_q : cnt_q + ONE;
    state_d     = (ready || cnt_q == LAST) ? READY : CLEAR;
    init_done_d = state_d == READY;
    wbits       = '0;
    for (int i = 0; i < LANES; i++) wbits[i*LANE_BITS +: LANE_BITS] = {LANE_BITS{w_mask[i]}};
    // CLEAR owns the write port; user writes only land once READY
    mem_we = ready ? (w_en && |w_mask) : 1'b1;
    mem_wa = ready ? w_addr : cnt_q[ADDR_BITS-1:0];
    mem_wd = ready ? ((mem_q[w_addr] & ~wbits) | (w_data & wbits)) : '0;
    s1_data_d  = s1_data_q;
    s1_valid_d = '0;
    r_data_d   = r_data_q;
    r_valid_d  = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_addr[p] = r_addr[p*ADDR_BITS +: ADDR_BITS];
      // write-first: a same-edge write to the same word is merged into the returned data
      rd_word[p] = (ready && w_en && w_addr == rd_addr[p]) ? ((mem_q[rd_addr[p]] & ~wbits) | (w_data & wbits)) : mem_q[rd_addr[p]];
      rd_acc[p]  = ready && r_en[p];
      s1_valid_d[p] = rd_acc[p];
      s1_data_d[p*DATA_BITS +: DATA_BITS] = rd_acc[p] ? rd_word[p] : s1_data_q[p*DATA_BITS +: DATA_BITS];
      r_valid_d[p] = READ_LATENCY == 1 ? rd_acc[p] : s1_valid_q[p];
      r_data_d[p*DATA_BITS +: DATA_BITS] = READ_LATENCY == 1 ?
        (rd_acc[p] ? rd_word[p] : r_data_q[p*DATA_BITS +: DATA_BITS]) :
        (s1_valid_q[p] ? s1_data_q[p*DATA_BITS +: DATA_BITS] : r_data_q[p*DATA_BITS +: DATA_BITS]);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      s1_data_q   <= '0;
      s1_valid_q  <= '0;
      r_data_q    <= '0;
      r_valid_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      r_data_q    <= r_data_d;
      r_valid_q   <= r_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end
  assign init_done = init_done_q;
  assign r_data    = r_data_q;
  assign r_valid   = r_valid_q;
endmodule

// File: tb/tb_banked_read_memory.sv
// tb_banked_read_memory: randomized and directed checks of banked_read_memory against an array-based reference model
module tb_banked_read_memory;
  localparam int AB = 4, DB = 16, NP = 2, DEPTH = 16;
  logic clk = 1'b0, rst = 1'b0, w_en = 1'b0;
  logic [AB-1:0] w_addr = '0;
  logic [DB-1:0] w_data = '0;
  logic [1:0] w_mask = '0;
  logic [NP-1:0] r_en = '0;
  logic [NP*AB-1:0] r_addr = '0;
  logic init1, init2, init0;
  logic [NP*DB-1:0] rd1, rd2, rd0;
  logic [NP-1:0] rv1, rv2, rv0;
  always #5 clk = ~clk;
  banked_read_memory #(.ADDR_BITS(AB), .DATA_BITS(DB), .LANE_BITS(8), .READ_PORTS(NP), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .init_done(init1), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_en(r_en), .r_addr(r_addr), .r_data(rd1), .r_valid(rv1));
  banked_read_memory #(.ADDR_BITS(AB), .DATA_BITS(DB), .LANE_BITS(8), .READ_PORTS(NP), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst(rst), .init_done(init2), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_en(r_en), .r_addr(r_addr), .r_data(rd2), .r_valid(rv2));
  banked_read_memory #(.ADDR_BITS(AB), .DATA_BITS(DB), .LANE_BITS(8), .READ_PORTS(NP), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u0 (
    .clk(clk), .rst(rst), .init_done(init0), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_en(r_en), .r_addr(r_addr), .r_data(rd0), .r_valid(rv0));
  logic [DB-1:0] mem_m [DEPTH];
  logic [DB-1:0] e1_data [NP];
  logic [DB-1:0] e2_data [NP];
  logic [DB-1:0] d_prev [NP];
  bit e1_valid [NP];
  bit e2_valid [NP];
  bit v_prev [NP];
  bit ready_m, init0_m;
  int cnt_m;
  int n_cmp, n_bad;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    ready_m = 1'b0;
    init0_m = 1'b0;
    cnt_m = 0;
    for (int p = 0; p < NP; p++) begin
      e1_data[p] = '0; e2_data[p] = '0; d_prev[p] = '0;
      e1_valid[p] = 1'b0; e2_valid[p] = 1'b0; v_prev[p] = 1'b0;
    end
  endtask
  // one clock edge of the reference: reads see the write-first word, then the write (or clear progress) lands
  task automatic model_edge();
    logic [DB-1:0] wb, word;
    logic [AB-1:0] a;
    wb = {{8{w_mask[1]}}, {8{w_mask[0]}}};
    for (int p = 0; p < NP; p++) begin
      e2_valid[p] = v_prev[p];
      if (v_prev[p]) e2_data[p] = d_prev[p];
      a = r_addr[p*AB +: AB];
      word = mem_m[a];
      if (w_en && w_addr == a) word = (word & ~wb) | (w_data & wb);
      v_prev[p] = ready_m && r_en[p];
      e1_valid[p] = v_prev[p];
      if (v_prev[p]) begin
        e1_data[p] = word;
        d_prev[p] = word;
      end
    end
    if (ready_m) begin
      if (w_en) mem_m[w_addr] = (mem_m[w_addr] & ~wb) | (w_data & wb);
    end else begin
      cnt_m++;
      if (cnt_m == DEPTH) begin
        ready_m = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end
    end
    init0_m = 1'b1;
  endtask
  task automatic check_outputs();
    chk("init_l1", init1, ready_m);
    chk("init_l2", init2, ready_m);
    chk("init_noclr", init0, init0_m);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("l1_valid%0d", p), rv1[p], e1_valid[p]);
      chk($sformatf("l1_data%0d", p), rd1[p*DB +: DB], e1_data[p]);
      chk($sformatf("l2_valid%0d", p), rv2[p], e2_valid[p]);
      chk($sformatf("l2_data%0d", p), rd2[p*DB +: DB], e2_data[p]);
    end
  endtask
  task automatic check_reset();
    chk("rst_init", {init0, init1, init2}, 0);
    chk("rst_valid", {rv1, rv2}, 0);
    chk("rst_data1", rd1, 0);
    chk("rst_data2", rd2, 0);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask
  task automatic idle_in();
    w_en = 1'b0; w_mask = '0; r_en = '0;
  endtask
  task automatic set_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [1:0] m);
    w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b1;
    model_reset();
  endtask
  initial begin
    int lo;
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    do_reset();
    // traffic during CLEAR must be ignored
    set_write(4'd2, 16'hFFFF, 2'b11);
    r_en = 2'b11;
    lo = 0;
    for (int i = 0; i < 40 && !init1; i++) begin step(); lo++; end
    chk("clear_len", lo, 16);
    idle_in();
    for (int i = 0; i < DEPTH; i++) begin
      r_en = 2'b11;
      r_addr = {4'(15 - i), 4'(i)};
      step();
      chk("clear_read", {rv1[0], rd1[15:0]}, 32'h10000);
    end
    idle_in();
    repeat (2) step();
    set_write(4'd3, 16'h11A5, 2'b01);
    step();
    idle_in(); r_en = 2'b01; r_addr = 8'h03;
    step();
    chk("lane_lo", rd1[15:0], 16'h00A5);
    idle_in(); set_write(4'd3, 16'h7700, 2'b10);
    step();
    idle_in(); r_en = 2'b01; r_addr = 8'h03;
    step();
    chk("lane_hi", rd1[15:0], 16'h77A5);
    idle_in(); set_write(4'd6, 16'h1234, 2'b11);
    step();
    set_write(4'd5, 16'h003C, 2'b11);
    r_en = 2'b11; r_addr = {4'd6, 4'd5};
    step();
    chk("byp_p0", {rv1[0], rd1[15:0]}, {15'd0, 1'b1, 16'h003C});
    chk("byp_p1", {rv1[1], rd1[31:16]}, {15'd0, 1'b1, 16'h1234});
    idle_in();
    for (int i = 1; i <= 3; i++) begin
      set_write(4'(i), 16'(i * 16), 2'b11);
      step();
    end
    idle_in();
    r_en = 2'b01; r_addr = 8'h01;
    step();
    chk("l2_gap", rv2[0], 0);
    r_addr = 8'h02;
    step();
    chk("l2_first", {rv2[0], rd2[15:0]}, {15'd0, 1'b1, 16'h0010});
    r_addr = 8'h03;
    step();
    chk("l2_second", {rv2[0], rd2[15:0]}, {15'd0, 1'b1, 16'h0020});
    idle_in();
    step();
    chk("l2_third", {rv2[0], rd2[15:0]}, {15'd0, 1'b1, 16'h0030});
    step();
    chk("l2_end", {rv2[0], rd2[15:0]}, {15'd0, 1'b0, 16'h0030});
    set_write(4'd9, 16'h005A, 2'b11);
    step();
    idle_in(); r_en = 2'b01; r_addr = 8'h09;
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold", {rv1[0], rd1[15:0]}, {15'd0, 1'b0, 16'h005A});
    end
    do_reset();
    set_write(4'd2, 16'hBEEF, 2'b11);
    repeat (7) step();
    #2 rst = 1'b0;
    #1 check_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    lo = 0;
    for (int i = 0; i < 40 && !init1; i++) begin step(); lo++; end
    chk("reclear_len", lo, 16);
    idle_in(); r_en = 2'b01; r_addr = 8'h02;
    step();
    chk("lost_write", {rv1[0], rd1[15:0]}, {15'd0, 1'b1, 16'h0000});
    idle_in();
    for (int i = 0; i < 400; i++) begin
      w_en = 1'($urandom_range(0, 1));
      w_addr = 4'($urandom_range(0, 7));
      w_data = 16'($urandom);
      w_mask = 2'($urandom);
      r_en = 2'($urandom);
      r_addr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      step();
    end
    idle_in();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
